// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command path: op codes, cmd_data bit fields,
// FSM state encoding and the decoded field bundle driven toward the finder.
package sprite_pkg;

  localparam logic [1:0] FN_LEVEL     = 2'b00;
  localparam logic [1:0] FN_POS       = 2'b01;
  localparam logic [1:0] FN_COLISION  = 2'b10;
  localparam logic [1:0] FN_ILLEGAL   = 2'b11;
  localparam logic [5:0] NO_SPRITE_ID = 6'h3F;

  localparam int CMD_W    = 32;
  localparam int OP_LSB   = 30;
  localparam int ID_LSB   = 24;
  localparam int COL_LSB  = 10;
  localparam int ROW_LSB  = 0;
  localparam int IN01_LSB = 6;
  localparam int IN02_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT_COL,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [1:0] sel;
    logic [5:0] id;
    logic [9:0] col;
    logic [9:0] row;
    logic [5:0] in01;
    logic [5:0] in02;
  } fields_t;

  function automatic logic [1:0] cmd_op(input logic [CMD_W-1:0] w);
    return w[OP_LSB +: 2];
  endfunction

  // Fields that the op does not use are forced to zero so the finder never sees stale data.
  function automatic fields_t decode_cmd(input logic [CMD_W-1:0] w);
    fields_t f;
    f      = '0;
    f.sel  = cmd_op(w);
    f.id   = w[ID_LSB +: 6];
    if (f.sel == FN_POS) begin
      f.col = w[COL_LSB +: 10];
      f.row = w[ROW_LSB +: 10];
    end
    if (f.sel == FN_COLISION) begin
      f.in01 = w[IN01_LSB +: 6];
      f.in02 = w[IN02_LSB +: 6];
    end
    return f;
  endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Small synchronous command FIFO; the head word is read straight from the register
// array so it is valid in the same cycle that empty deasserts.
module sprite_cmd_fifo
  import sprite_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/sprite_cmd_issuer.sv
// Buffers host sprite commands and replays them to the finder as a one-cycle strobe
// with fields held through a settle window; collision queries return hit/miss.
module sprite_cmd_issuer
  import sprite_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int COL_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CMD_W-1:0] cmd_data_i,
  input  logic             active_finder_position_i,
  input  logic             function_sp_colision_out_i,
  output logic             active_function_processor_o,
  output logic [1:0]       function_selector_o,
  output logic [5:0]       function_id_sprit_o,
  output logic [9:0]       function_col_o,
  output logic [9:0]       function_row_o,
  output logic [5:0]       function_input01_o,
  output logic [5:0]       function_input02_o,
  output logic             col_valid_o,
  output logic             col_hit_o,
  output logic             busy_o,
  output logic [7:0]       illegal_cnt_o
);

  localparam int TMR_W = 8;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic [CMD_W-1:0]              fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          accept;
  logic                          is_illegal;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             hit_seen_q, hit_seen_d;
  logic             col_hit_q, col_hit_d;
  fields_t          fields_q, fields_d;
  logic [7:0]       illegal_q, illegal_d;

  assign cmd_ready_o = !fifo_full;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign is_illegal  = (cmd_op(cmd_data_i) == FN_ILLEGAL);
  assign fifo_push   = accept && !is_illegal;
  assign illegal_d   = (accept && is_illegal && illegal_q != 8'hFF) ? illegal_q + 8'd1 : illegal_q;

  sprite_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (cmd_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      hit_seen_q <= 1'b0;
      col_hit_q  <= 1'b0;
      fields_q   <= '0;
      illegal_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      hit_seen_q <= hit_seen_d;
      col_hit_q  <= col_hit_d;
      fields_q   <= fields_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    hit_seen_d = hit_seen_q;
    col_hit_d  = col_hit_q;
    fields_d   = fields_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !active_finder_position_i) begin
          fifo_pop = 1'b1;
          fields_d = decode_cmd(fifo_head);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_d      = TMR_W'(HOLD_CYCLES - 1);
        hit_seen_d = 1'b0;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        // An early flag from the finder is remembered and reported as a hit later.
        if (function_sp_colision_out_i) hit_seen_d = 1'b1;
        if (tmr_q == '0) begin
          if (fields_q.sel == FN_COLISION) begin
            tmr_d   = TMR_W'(COL_TIMEOUT - 1);
            state_d = ST_WAIT_COL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_WAIT_COL: begin
        if (function_sp_colision_out_i || hit_seen_q) begin
          col_hit_d = 1'b1;
          state_d   = ST_RESP;
        end else if (tmr_q == '0) begin
          col_hit_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active_function_processor_o = (state_q == ST_ISSUE);
    col_valid_o                 = (state_q == ST_RESP);
    busy_o                      = (state_q != ST_IDLE) || (fifo_count != '0);
  end

  assign function_selector_o = fields_q.sel;
  assign function_id_sprit_o = fields_q.id;
  assign function_col_o      = fields_q.col;
  assign function_row_o      = fields_q.row;
  assign function_input01_o  = fields_q.in01;
  assign function_input02_o  = fields_q.in02;
  assign col_hit_o           = col_hit_q;
  assign illegal_cnt_o       = illegal_q;

endmodule
